// File: rtl/qam_pkg.sv
// Shared QAM transmitter definitions: modulation widths and bps clamp.
package qam_pkg;

    localparam int BPS_BPSK     = 1;
    localparam int BPS_QPSK     = 2;
    localparam int BPS_16QAM    = 4;
    localparam int BPS_64QAM    = 6;
    localparam int MAX_BITS_DEF = 6;

    function automatic int unsigned clamp_bps(
        input int unsigned bps,
        input int unsigned max_bits
    );
        if (bps == 0) return 1;
        else if (bps > max_bits) return max_bits;
        else return bps;
    endfunction

endpackage

// File: rtl/spc_out_reg.sv
// Single-entry valid/ready holding register for completed symbols.
module spc_out_reg
    import qam_pkg::*;
#(
    parameter int W = MAX_BITS_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] din,
    input  logic         ready,
    output logic [W-1:0] dout,
    output logic         valid
);

    always_ff @(posedge clk) begin
        if (rst) begin
            dout  <= '0;
            valid <= 1'b0;
        end else if (load) begin
            dout  <= din;
            valid <= 1'b1;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/spc_param.sv
// Parametrised serial-to-parallel converter, 1..MAX_BITS bits per symbol.
// Define SPC_BITREV_EN to add the msb_first bit-order select port.
module spc_param
    import qam_pkg::*;
#(
    parameter int MAX_BITS = MAX_BITS_DEF,
    parameter int BPS_W    = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                Din,
    output logic                in_ready,
    input  logic [BPS_W-1:0]    bps,
    input  logic                flush,
`ifdef SPC_BITREV_EN
    input  logic                msb_first,
`endif
    output logic [MAX_BITS-1:0] sym_out,
    output logic                sym_valid,
    input  logic                sym_ready
);

    logic [MAX_BITS-1:0] shift;
    logic [MAX_BITS-1:0] shift_nxt;
    logic [MAX_BITS-1:0] mask;
    logic [BPS_W-1:0]    count;
    logic [BPS_W-1:0]    lat_bps;
    logic [BPS_W-1:0]    eff_bps;
    logic                first;
    logic                last;
    logic                accept;
    logic                done;
    logic                eff_msb;
`ifdef SPC_BITREV_EN
    logic                lat_msb;
`endif

    // On the first bit the live bps applies, so refusal covers 1-bit symbols too
    always_comb begin
        first    = (count == '0);
        eff_bps  = first ? BPS_W'(clamp_bps(32'(bps), MAX_BITS)) : lat_bps;
        last     = (count == eff_bps - BPS_W'(1));
        in_ready = rst || !(sym_valid && !sym_ready && last);
        accept   = en && in_ready && !flush;
        done     = accept && last;
        mask     = MAX_BITS'((32'd1 << eff_bps) - 32'd1);
`ifdef SPC_BITREV_EN
        eff_msb  = first ? msb_first : lat_msb;
`else
        eff_msb  = 1'b1;
`endif
        if (eff_msb)
            shift_nxt = ((shift << 1) | MAX_BITS'(Din)) & mask;
        else
            shift_nxt = shift | (MAX_BITS'(Din) << count);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift   <= '0;
            count   <= '0;
            lat_bps <= BPS_W'(1);
`ifdef SPC_BITREV_EN
            lat_msb <= 1'b1;
`endif
        end else if (flush) begin
            shift <= '0;
            count <= '0;
        end else if (accept) begin
            if (first) begin
                lat_bps <= eff_bps;
`ifdef SPC_BITREV_EN
                lat_msb <= eff_msb;
`endif
            end
            if (done) begin
                shift <= '0;
                count <= '0;
            end else begin
                shift <= shift_nxt;
                count <= count + BPS_W'(1);
            end
        end
    end

    spc_out_reg #(
        .W(MAX_BITS)
    ) u_out (
        .clk  (clk),
        .rst  (rst),
        .load (done),
        .din  (shift_nxt),
        .ready(sym_ready),
        .dout (sym_out),
        .valid(sym_valid)
    );

endmodule

// File: tb/tb_spc_param.sv
// Scoreboard bench for spc_param: directed scenarios plus random traffic.
module tb_spc_param;

    localparam int MAXB = 6;

    logic            clk = 1'b0;
    logic            rst;
    logic            en;
    logic            Din;
    logic            in_ready;
    logic [2:0]      bps;
    logic            flush;
    logic            msb_first;
    logic [MAXB-1:0] sym_out;
    logic            sym_valid;
    logic            sym_ready;

    int tests = 0;
    int fails = 0;

    int  q[$];
    int  bits[$];
    int  m_w = 1;
    bit  m_msb = 1'b1;
    bit  m_valid = 1'b0;
    bit  prev_rst = 1'b0;

    spc_param dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .Din      (Din),
        .in_ready (in_ready),
        .bps      (bps),
        .flush    (flush),
`ifdef SPC_BITREV_EN
        .msb_first(msb_first),
`endif
        .sym_out  (sym_out),
        .sym_valid(sym_valid),
        .sym_ready(sym_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", n, act, exp);
        end
    endtask

    function automatic int clampm(input int b);
        if (b < 1) return 1;
        if (b > MAXB) return MAXB;
        return b;
    endfunction

    // One cycle: drive after posedge, predict and check at negedge
    task automatic step(input bit r, input bit e, input bit d, input int b,
                        input bit f, input bit rdy, input bit m);
        int  w;
        int  v;
        bit  exp_rdy;
        bit  hs;
        bit  comp;
        @(posedge clk);
        #1;
        rst       = r;
        en        = e;
        Din       = d;
        bps       = 3'(b);
        flush     = f;
        sym_ready = r ? 1'b0 : rdy;
        msb_first = m;
        @(negedge clk);
        if (prev_rst) begin
            chk("rst_valid", int'(sym_valid), 0);
            chk("rst_sym_out", int'(sym_out), 0);
        end
        if (r) begin
            exp_rdy = 1'b1;
        end else begin
            w = (bits.size() == 0) ? clampm(b) : m_w;
            exp_rdy = !(m_valid && !sym_ready && (bits.size() + 1 == w));
        end
        chk("in_ready", int'(in_ready), int'(exp_rdy));
        if (r) begin
            bits.delete();
            q.delete();
            m_valid = 1'b0;
            m_w = 1;
        end else begin
            hs = m_valid && sym_ready;
            comp = 1'b0;
            if (f) begin
                bits.delete();
            end else if (e && exp_rdy) begin
                if (bits.size() == 0) begin
                    m_w = clampm(b);
`ifdef SPC_BITREV_EN
                    m_msb = m;
`else
                    m_msb = 1'b1;
`endif
                end
                bits.push_back(int'(d));
                if (bits.size() == m_w) begin
                    v = 0;
                    for (int i = 0; i < m_w; i++)
                        v += bits[i] << (m_msb ? (m_w - 1 - i) : i);
                    q.push_back(v);
                    bits.delete();
                    comp = 1'b1;
                end
            end
            m_valid = comp ? 1'b1 : (hs ? 1'b0 : m_valid);
        end
        prev_rst = r;
    endtask

    task automatic bits_in(input int b, input int pat, input int n,
                           input bit rdy, input bit m);
        for (int i = n - 1; i >= 0; i--)
            step(0, 1, pat[i], b, 0, rdy, m);
    endtask

    // Monitor: pops on every handshake, checks hold while stalled
    initial begin : monitor
        bit              held;
        logic [MAXB-1:0] held_val;
        held = 1'b0;
        held_val = '0;
        forever begin
            @(negedge clk);
            if (sym_valid && held)
                chk("hold_stable", int'(sym_out), int'(held_val));
            if (sym_valid && sym_ready) begin
                if (q.size() == 0)
                    chk("unexpected_sym", int'(sym_out), -1);
                else
                    chk("sym_out", int'(sym_out), q.pop_front());
            end
            held = sym_valid && !sym_ready;
            held_val = sym_out;
        end
    end

    initial begin : driver
        rst = 1'b1;
        en = 1'b0;
        Din = 1'b0;
        bps = 3'd1;
        flush = 1'b0;
        sym_ready = 1'b0;
        msb_first = 1'b1;
        step(1, 0, 0, 1, 0, 0, 1);
        step(1, 0, 0, 1, 0, 0, 1);
        step(0, 0, 0, 1, 0, 1, 1);
        // QPSK back-to-back: 2 then 3
        bits_in(2, 'b1011, 4, 1, 1);
        step(0, 0, 0, 2, 0, 1, 1);
        // 64QAM: 45 held while 5 more bits stream, sixth refused
        bits_in(6, 'b101101, 6, 1, 1);
        bits_in(6, 'b01100, 5, 0, 1);
        step(0, 1, 1, 6, 0, 0, 1);
        step(0, 1, 1, 6, 0, 1, 1);
        step(0, 0, 0, 6, 0, 1, 1);
        step(0, 0, 0, 6, 0, 1, 1);
        // Clamp: bps=0 -> 1 bit, bps=7 -> 6 bits
        step(0, 1, 1, 0, 0, 1, 1);
        bits_in(7, 'b110010, 6, 1, 1);
        step(0, 0, 0, 1, 0, 1, 1);
        // Flush with a pending symbol, then 1111 at bps=4
        step(0, 1, 1, 1, 0, 0, 1);
        bits_in(4, 'b101, 3, 0, 1);
        step(0, 1, 0, 4, 1, 0, 1);
        bits_in(4, 'b1111, 4, 1, 1);
        step(0, 0, 0, 4, 0, 1, 1);
        // Reset mid-symbol with a held output, then 10 at bps=2
        step(0, 1, 1, 1, 0, 0, 1);
        step(0, 1, 1, 2, 0, 0, 1);
        step(1, 0, 0, 2, 0, 0, 1);
        bits_in(2, 'b10, 2, 1, 1);
        step(0, 0, 0, 2, 0, 1, 1);
`ifdef SPC_BITREV_EN
        bits_in(4, 'b1100, 4, 1, 0);
        bits_in(4, 'b1100, 4, 1, 1);
        step(0, 0, 0, 4, 0, 1, 1);
`endif
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 99) < 2,
                 $urandom_range(0, 99) < 75,
                 1'($urandom),
                 int'($urandom_range(0, 7)),
                 $urandom_range(0, 99) < 4,
                 $urandom_range(0, 99) < 60,
                 1'($urandom));
        end
        for (int i = 0; i < 8; i++)
            step(0, 0, 0, 1, 0, 1, 1);
        chk("queue_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/spc_param.md
Name: spc_param

Overview:
- Parametrised serial-to-parallel converter: the successor to the fixed 2-bit SPC in the QAM transmitter.
- Packs a serial bit stream into symbols of runtime-selectable width, 1..MAX_BITS bits, covering BPSK through 64-QAM.
- Presents each completed symbol on a valid/ready output to the constellation mapper.
- Stalls the serial source via in_ready when the mapper back-pressures.

Parameters:
- MAX_BITS, 6, maximum bits per symbol; width of sym_out.
- BPS_W, 3, width of the bps select port; must satisfy 2^BPS_W > MAX_BITS.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  serial bit valid; a bit is accepted when en && in_ready.
- Din  in  1  serial data bit.
- in_ready  out  1  block can accept a bit this cycle.
- bps  in  BPS_W  bits per symbol; sampled only when the first bit of a symbol is accepted.
- flush  in  1  synchronous discard of any partially assembled symbol.
- sym_out  out  MAX_BITS  completed symbol, right-aligned; bits above the latched bps are 0.
- sym_valid  out  1  sym_out holds an unconsumed symbol.
- sym_ready  in  1  consumer accepts sym_out when sym_valid && sym_ready.
- msb_first  in  1  bit order select; present only with SPC_BITREV_EN.

Behaviour:
- Reset is synchronous and active-high: on a clk edge with rst=1, all state clears.
  - Reset values: sym_out=0, sym_valid=0, internal shift register=0, bit count=0, latched bps=1.
  - in_ready is combinational and reads 1 during and after reset.
  - A reset mid-symbol discards the partial symbol and any held output.
- Width clamp when bps is sampled: bps=0 is treated as 1; bps>MAX_BITS is treated as MAX_BITS.
- Accumulation, on each accepted bit:
  - Fixed MSB-first: shift = (shift<<1)|Din, masked to the latched width.
  - Count increments.
  - On the first bit (count=0), the clamped bps is latched and held for the whole symbol.
- Completion:
  - When the accepted bit is bit number latched_bps (count==latched_bps-1), the full shift value is loaded into sym_out and sym_valid is set on the next edge.
  - Count returns to 0.
  - Latency is 1 clk from the last accepted bit to sym_valid.
- Back-to-back symbols: a new symbol can start on the cycle right after completion, with no bubble.
- Output handshake:
  - sym_valid stays high and sym_out stays stable until sym_valid && sym_ready.
  - When the handshake occurs and no new symbol completes that cycle, sym_valid clears.
- Simultaneous drain and completion: when a handshake and a completing bit occur in the same cycle, sym_out loads the new symbol and sym_valid stays 1.
- in_ready = !(sym_valid && !sym_ready && count==latched_bps-1).
  - The block refuses only the bit that would overwrite an unconsumed symbol.
  - Partial bits are still accepted while the output is stalled.
- en=0: state holds; Din is ignored.
- flush:
  - Clears count and the shift register on the next edge.
  - Does not affect sym_out or sym_valid.
  - An en bit in the same cycle is dropped.
  - rst has priority over flush.
- Runtime bps change mid-symbol has no effect until the next symbol start.
- bps=1 gives one symbol per accepted bit, equal to Din, at full throughput.
- No overflow is possible by construction: nothing is ever silently lost.

Optional Feature:
- Macro: SPC_BITREV_EN.
- Defined:
  - The msb_first port exists and is sampled together with bps at symbol start.
  - msb_first=1 gives the MSB-first behaviour above.
  - msb_first=0 places the first bit at sym_out[0] and bit k at sym_out[k] (LSB-first).
- Undefined: the port is absent and the order is fixed MSB-first, matching the existing 2-bit SPC ordering.

Decomposition:
- Shared package (qam_pkg) holds:
  - Per-modulation bps constants: BPS_BPSK=1, BPS_QPSK=2, BPS_16QAM=4, BPS_64QAM=6.
  - Default MAX_BITS.
  - The clamp function.
- One natural sub-module: spc_out_reg, the single-entry valid/ready holding register.
- Accumulation stays in the top level.

Test Plan:
- QPSK, bps=2, MSB-first, sym_ready=1, Din=1,0,1,1 on consecutive cycles -> sym_out=2 then 3, each with a 1-clk sym_valid, no gaps.
- 64QAM, bps=6, Din=1,0,1,1,0,1, then sym_ready=0 for 5 cycles while streaming 5 more bits and presenting a sixth:
  - sym_out holds 45 throughout.
  - in_ready drops only for the sixth bit.
  - Releasing sym_ready completes the second symbol with no lost bits.
- bps=0 then bps=7 with MAX_BITS=6 -> clamped: the first symbol completes after 1 bit, the second after 6 bits.
- flush after 3 of 4 bits (bps=4), then send 1,1,1,1 -> sym_out=15; the flushed bits never appear; a pending sym_valid is unaffected.
- rst asserted mid-symbol with sym_valid=1 -> next edge sym_valid=0, sym_out=0, in_ready=1; the next 2 bits 1,0 at bps=2 give sym_out=2.
- SPC_BITREV_EN with msb_first=0, bps=4, Din=1,1,0,0 -> sym_out=3; the same stream with msb_first=1 -> sym_out=12.
